// File: rtl/pc_sequencer.sv
// Registered program counter: JMP/conditional branches, stall, redirect, taken-branch counter.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_sequencer #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned RESET_ADDR = 0,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned RAS_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              instr_valid,
  input  logic [31:0]       instruction,
  input  logic [15:0]       src2,
  input  logic              use_reg,
  input  logic [3:0]        flags,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] next_pc,
  output logic              flush,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic              ras_err
);

  localparam logic [7:0] OP_CALL = 8'h40;
`ifdef PC_RAS_EN
  localparam logic [7:0] OP_RET  = 8'h41;
`endif

  logic              z_f, c_f, s_f, o_f;
  logic              is_br;
  logic [3:0]        cond;
  logic              cond_true;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_inc;
  logic              flush_d;
  logic              cnt_inc;
  logic              unused_bits;

  assign {o_f, s_f, c_f, z_f} = flags;
  assign is_br       = (instruction[31:29] == 3'b010) && instruction[27];
  assign cond        = {instruction[28], instruction[26:24]};
  assign target      = ADDR_W'(use_reg ? src2 : instruction[15:0]);
  assign pc_inc      = pc + ADDR_W'(1);
  assign unused_bits = ^instruction[23:16];

  // Branch condition evaluation over {O,S,C,Z}
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'd0:  cond_true = 1'b1;
      4'd1:  cond_true = z_f;
      4'd2:  cond_true = !z_f;
      4'd3:  cond_true = (s_f == o_f);
      4'd4:  cond_true = z_f | (s_f != o_f);
      4'd5:  cond_true = (s_f != o_f);
      4'd6:  cond_true = !z_f & (s_f == o_f);
      4'd7:  cond_true = o_f;
      4'd8:  cond_true = c_f;
      4'd9:  cond_true = s_f;
      4'd10: cond_true = !s_f;
      4'd11: cond_true = !c_f;
      4'd12: cond_true = c_f | z_f;
      4'd13: cond_true = !c_f & !z_f;
      4'd14: cond_true = c_f;
      4'd15: cond_true = !o_f;
      default: cond_true = 1'b0;
    endcase
  end

`ifdef PC_RAS_EN
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned LVL_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_wr;
  logic [PTR_W-1:0]  ras_wr_inc;
  logic [PTR_W-1:0]  ras_top;
  logic [LVL_W-1:0]  ras_lvl;
  logic              ras_push;
  logic              ras_pop;
  logic              err_d;

  // Circular write pointer; ras_top is the most recent entry
  assign ras_wr_inc = (ras_wr == PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_wr + PTR_W'(1);
  assign ras_top    = (ras_wr == '0) ? PTR_W'(RAS_DEPTH - 1) : ras_wr - PTR_W'(1);
`endif

  // Next-PC selection: redirect > stall > taken > sequential
  always_comb begin
    next_pc = pc_inc;
    flush_d = 1'b0;
    cnt_inc = 1'b0;
`ifdef PC_RAS_EN
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    err_d    = 1'b0;
`endif
    if (redirect_valid) begin
      next_pc = redirect_addr;
      flush_d = 1'b1;
    end else if (stall) begin
      next_pc = pc;
    end else if (instr_valid) begin
      if (is_br && cond_true) begin
        next_pc = target;
        flush_d = 1'b1;
        cnt_inc = 1'b1;
      end else if (instruction[31:24] == OP_CALL) begin
        next_pc = target;
        flush_d = 1'b1;
        cnt_inc = 1'b1;
`ifdef PC_RAS_EN
        ras_push = 1'b1;
`endif
      end
`ifdef PC_RAS_EN
      else if (instruction[31:24] == OP_RET) begin
        if (ras_lvl != '0) begin
          next_pc = ras_mem[ras_top];
          flush_d = 1'b1;
          cnt_inc = 1'b1;
          ras_pop = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= ADDR_W'(RESET_ADDR);
      flush     <= 1'b0;
      taken_cnt <= '0;
    end else begin
      pc    <= next_pc;
      flush <= flush_d;
      if (cnt_inc && (taken_cnt != '1)) begin
        taken_cnt <= taken_cnt + CNT_W'(1);
      end
    end
  end

`ifdef PC_RAS_EN
  // Stack pointer and fill level; a full push overwrites the oldest slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_wr  <= '0;
      ras_lvl <= '0;
      ras_err <= 1'b0;
    end else begin
      ras_err <= err_d;
      if (ras_push) begin
        ras_wr <= ras_wr_inc;
        if (ras_lvl != LVL_W'(RAS_DEPTH)) begin
          ras_lvl <= ras_lvl + LVL_W'(1);
        end
      end else if (ras_pop) begin
        ras_wr  <= ras_top;
        ras_lvl <= ras_lvl - LVL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ras_push) begin
      ras_mem[ras_wr] <= pc_inc;
    end
  end
`else
  logic unused_ras_cfg;
  assign unused_ras_cfg = (RAS_DEPTH == 0);
  assign ras_err        = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed cases plus randomized traffic vs. a behavioural model.
module tb_pc_sequencer;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned RAS_DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall, instr_valid, use_reg, redirect_valid;
  logic [31:0]       instruction;
  logic [15:0]       src2;
  logic [3:0]        flags;
  logic [ADDR_W-1:0] redirect_addr;
  logic [ADDR_W-1:0] pc, next_pc;
  logic              flush, ras_err;
  logic [15:0]       taken_cnt;
  logic [ADDR_W-1:0] s_pc, s_next_pc;
  logic              s_flush, s_err;
  logic [1:0]        s_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  logic [15:0] m_pc;
  logic        m_flush, m_err;
  int          m_cnt;
  logic [15:0] m_ras[$];

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_W(ADDR_W), .RESET_ADDR(0), .CNT_W(16), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .instr_valid(instr_valid), .instruction(instruction),
    .src2(src2), .use_reg(use_reg), .flags(flags), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .pc(pc), .next_pc(next_pc), .flush(flush),
    .taken_cnt(taken_cnt), .ras_err(ras_err));

  pc_sequencer #(.ADDR_W(ADDR_W), .RESET_ADDR(0), .CNT_W(2), .RAS_DEPTH(RAS_DEPTH)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall), .instr_valid(instr_valid), .instruction(instruction),
    .src2(src2), .use_reg(use_reg), .flags(flags), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .pc(s_pc), .next_pc(s_next_pc), .flush(s_flush),
    .taken_cnt(s_cnt), .ras_err(s_err));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic z, cf, s, o;
    {o, s, cf, z} = f;
    case (c)
      4'd0:  return 1'b1;
      4'd1:  return z;
      4'd2:  return !z;
      4'd3:  return s == o;
      4'd4:  return z || (s != o);
      4'd5:  return s != o;
      4'd6:  return !z && (s == o);
      4'd7:  return o;
      4'd8:  return cf;
      4'd9:  return s;
      4'd10: return !s;
      4'd11: return !cf;
      4'd12: return cf || z;
      4'd13: return !cf && !z;
      4'd14: return cf;
      default: return !o;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [15:0] s2, input logic ur,
                       input logic [3:0] fl, input logic st, input logic rv, input logic [15:0] ra);
    instr_valid = v; instruction = ins; src2 = s2; use_reg = ur;
    flags = fl; stall = st; redirect_valid = rv; redirect_addr = ra;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 16'h0, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic model_reset();
    m_pc = 16'h0; m_flush = 1'b0; m_err = 1'b0; m_cnt = 0;
    m_ras.delete();
  endtask

  // One clock with the currently driven inputs; predicts, advances, then checks registered outputs
  task automatic step(input string tag);
    logic [15:0] npc, tgt;
    logic        nfl, nerr, push, pop, tk;
    logic [7:0]  op;
    #1;
    op  = instruction[31:24];
    tgt = use_reg ? src2 : instruction[15:0];
    npc = m_pc + 16'd1; nfl = 1'b0; nerr = 1'b0; push = 1'b0; pop = 1'b0; tk = 1'b0;
    if (redirect_valid) begin
      npc = redirect_addr; nfl = 1'b1;
    end else if (stall) begin
      npc = m_pc;
    end else if (instr_valid) begin
      if (instruction[31:29] == 3'b010 && instruction[27] &&
          cond_ok({instruction[28], instruction[26:24]}, flags)) begin
        npc = tgt; nfl = 1'b1; tk = 1'b1;
      end else if (op == 8'h40) begin
        npc = tgt; nfl = 1'b1; tk = 1'b1;
`ifdef PC_RAS_EN
        push = 1'b1;
`endif
      end
`ifdef PC_RAS_EN
      else if (op == 8'h41) begin
        if (m_ras.size() > 0) begin
          npc = m_ras[m_ras.size()-1]; nfl = 1'b1; tk = 1'b1; pop = 1'b1;
        end else begin
          nerr = 1'b1;
        end
      end
`endif
    end
    chk($sformatf("%s.next_pc", tag), 32'(next_pc), 32'(npc));
    chk($sformatf("%s.sat_next_pc", tag), 32'(s_next_pc), 32'(npc));
    @(posedge clk);
    #1;
    if (push) begin
      m_ras.push_back(m_pc + 16'd1);
      if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
    end
    if (pop) void'(m_ras.pop_back());
    m_pc = npc; m_flush = nfl; m_err = nerr;
    if (tk) m_cnt++;
    chk($sformatf("%s.pc", tag), 32'(pc), 32'(m_pc));
    chk($sformatf("%s.flush", tag), 32'(flush), 32'(m_flush));
    chk($sformatf("%s.taken_cnt", tag), 32'(taken_cnt), 32'((m_cnt > 65535) ? 65535 : m_cnt));
    chk($sformatf("%s.sat_cnt", tag), 32'(s_cnt), 32'((m_cnt > 3) ? 3 : m_cnt));
    chk($sformatf("%s.ras_err", tag), 32'(ras_err), 32'(m_err));
    chk($sformatf("%s.sat_pc", tag), 32'(s_pc), 32'(m_pc));
    chk($sformatf("%s.sat_flush", tag), 32'(s_flush), 32'(m_flush));
    chk($sformatf("%s.sat_err", tag), 32'(s_err), 32'(m_err));
  endtask

  initial begin
    logic [31:0] ins;
    int          sel;

    // Reset and sequential count
    rst = 1'b1;
    idle();
    model_reset();
    @(posedge clk);
    #1;
    chk("reset.pc", 32'(pc), 32'h0);
    chk("reset.flush", 32'(flush), 32'h0);
    chk("reset.taken_cnt", 32'(taken_cnt), 32'h0);
    chk("reset.ras_err", 32'(ras_err), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step("seq");
    chk("seq.pc_at_5", 32'(pc), 32'h5);

    // JMP with immediate target, then sequential continuation
    drive(1'b1, 32'h4800_1234, 16'h0, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0);
    step("jmp");
    chk("jmp.pc", 32'(pc), 32'h1234);
    chk("jmp.flush", 32'(flush), 32'h1);
    idle();
    step("jmp_next");
    chk("jmp_next.pc", 32'(pc), 32'h1235);

    // Every condition against every flag combination, register target
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        ins = $urandom;
        ins[31:29] = 3'b010; ins[28] = c[3]; ins[27] = 1'b1; ins[26:24] = c[2:0];
        drive(1'b1, ins, 16'h7D00, 1'b1, 4'(f), 1'b0, 1'b0, 16'h0);
        step($sformatf("cond%0d_f%0d", c, f));
      end
    end

    // Stall blocks a taken BEE; redirect beats stall and BNE
    idle();
    step("pre_stall");
    drive(1'b1, 32'h4900_0042, 16'h0, 1'b0, 4'h1, 1'b1, 1'b0, 16'h0);
    step("stall_bee");
    drive(1'b1, 32'h4A00_0042, 16'h0, 1'b0, 4'h0, 1'b1, 1'b1, 16'hBEEF);
    step("redir");
    chk("redir.pc", 32'(pc), 32'hBEEF);

    // PC wrap at all-ones
    drive(1'b0, 32'h0, 16'h0, 1'b0, 4'h0, 1'b0, 1'b1, 16'hFFFF);
    step("to_ffff");
    idle();
    step("wrap");
    chk("wrap.pc", 32'(pc), 32'h0);

    // Counter saturation on the narrow instance
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h4800_0000 | 32'(i * 3), 16'h0, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0);
      step("sat_jmp");
    end
    chk("sat.cnt", 32'(s_cnt), 32'h3);

    // CALL x3 into a 2-deep stack, then RET x3
    drive(1'b0, 32'h0, 16'h0, 1'b0, 4'h0, 1'b0, 1'b1, 16'd10);
    step("to_10");
    drive(1'b1, 32'h4000_0014, 16'h0, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0);
    step("call10");
    drive(1'b1, 32'h4000_001E, 16'h0, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0);
    step("call20");
    drive(1'b1, 32'h4000_0028, 16'h0, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0);
    step("call30");
    chk("call30.pc", 32'(pc), 32'd40);
    drive(1'b1, 32'h4100_0000, 16'h0, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0);
    step("ret1");
    step("ret2");
    step("ret3");
`ifdef PC_RAS_EN
    chk("ret3.pc", 32'(pc), 32'd22);
    chk("ret3.ras_err", 32'(ras_err), 32'h1);
`else
    chk("ret3.pc", 32'(pc), 32'd43);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 9));
      ins = $urandom;
      if (sel < 4) begin
        ins[31:29] = 3'b010; ins[27] = 1'b1;
      end else if (sel == 4) begin
        ins[31:24] = 8'h40;
      end else if (sel == 5) begin
        ins[31:24] = 8'h41;
      end
      drive($urandom_range(0, 5) != 0, ins, 16'($urandom), 1'($urandom), 4'($urandom),
            $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, 16'($urandom));
      step("rand");
    end

    // Asynchronous reset with a taken JMP pending
    drive(1'b1, 32'h4800_5555, 16'h0, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.pc", 32'(pc), 32'h0);
    chk("async_rst.flush", 32'(flush), 32'h0);
    chk("async_rst.taken_cnt", 32'(taken_cnt), 32'h0);
    chk("async_rst.next_pc", 32'(next_pc), 32'h5555);
    @(posedge clk);
    #1;
    chk("hold_rst.pc", 32'(pc), 32'h0);
    rst = 1'b0;
    model_reset();
    idle();
    step("post_rst");
    chk("post_rst.pc", 32'(pc), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Registered program-counter unit; parametrised successor to the combinational next-pointer counter.
- Holds the architectural PC and resolves JMP and the 15 flag-conditioned branches (BEE..BNO).
- Handles pipeline stall, external redirects (trap/interrupt) and a saturating taken-branch counter.
- Sits between decode (instruction, src2, flags) and fetch (pc, flush).

Parameters:
- ADDR_W, 16, PC width in bits; must be >= 16; targets are zero-extended from 16 bits.
- RESET_ADDR, 0, PC value loaded on reset.
- CNT_W, 16, width of the taken-branch counter.
- RAS_DEPTH, 4, return-address-stack entries (used only with PC_RAS_EN).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC; instruction ignored this cycle.
- instr_valid  in  1  instruction/src2/flags are valid this cycle.
- instruction  in  32  decoded instruction word.
- src2  in  16  register operand, used as the target when use_reg=1.
- use_reg  in  1  1: target=src2; 0: target=instruction[15:0].
- flags  in  4  {O,S,C,Z} = flags[3:0].
- redirect_valid  in  1  external redirect request.
- redirect_addr  in  ADDR_W  redirect target.
- pc  out  ADDR_W  current PC (registered).
- next_pc  out  ADDR_W  combinational value pc takes at the next edge.
- flush  out  1  registered; 1 for one cycle after any taken branch or redirect.
- taken_cnt  out  CNT_W  saturating count of taken branches (redirects excluded).
- ras_err  out  1  registered one-cycle pulse on RAS underflow (0 without PC_RAS_EN).

Behaviour:
- Reset (async, active-high): pc=RESET_ADDR; flush=0; taken_cnt=0; ras_err=0; RAS pointer=0. Asserting rst mid-operation discards the pending update.
- Branch decode: is_br = (instruction[31:29]==3'b010) && instruction[27]. cond = {instruction[28], instruction[26:24]}.
- Conditions by cond value:
  - 0 JMP: always taken.
  - 1 EE: Z. 2 NE: !Z.
  - 3 GE: S==O. 4 LE: Z|(S!=O). 5 LL: S!=O. 6 GG: !Z&(S==O).
  - 7 OO: O. 8 BS: C. 9 SS: S. 10 NS: !S.
  - 11 AE: !C. 12 BE: C|Z. 13 AA: !C&!Z. 14 BB: C. 15 NO: !O.
- taken = instr_valid & !stall & is_br & cond_true.
- Priority, evaluated each edge:
  1. redirect_valid: pc<=redirect_addr, flush<=1. Applies even when stall=1; any branch in the same cycle is dropped and not counted.
  2. stall: pc held, flush<=0.
  3. taken: pc<=zero-extended target, flush<=1, taken_cnt+1 (saturates at all-ones).
  4. otherwise: pc<=pc+1, wrapping modulo 2^ADDR_W (all-ones -> 0); flush<=0.
- instr_valid=0 with no stall or redirect: pc still increments.
- Latency: a branch presented in cycle N appears on pc in cycle N+1; flush is high in cycle N+1.
- next_pc always equals the value pc takes at the next edge, excluding reset.

Optional Feature:
- Macro: PC_RAS_EN.
- Defined: instruction[31:24]==8'h40 is CALL and 8'h41 is RET; both are subject to stall/redirect priority.
  - CALL: pushes pc+1, then jumps to target (counted as taken).
  - RET: pops into pc (counted as taken).
  - Push when full: the oldest entry is overwritten (circular buffer).
  - RET when empty: pc<=pc+1, ras_err pulses for 1 cycle, not counted.
  - Redirect does not modify the RAS.
- Undefined: no RAS storage. CALL acts as an unconditional jump without a push; RET acts as a non-branch (pc+1); ras_err is tied to 0.

Test Plan:
- Reset release with RESET_ADDR=0: pc=0,1,2,3 over 4 cycles; flush=0; taken_cnt=0.
- JMP 0x4800_1234 with use_reg=0 at pc=5: next cycle pc=0x1234, flush=1 for one cycle, taken_cnt=1; following cycle pc=0x1235.
- All 16 conditions over every flags value 0..15, src2=0x7D00, use_reg=1: taken exactly per the condition list, checked against a reference model.
- Stall=1 plus BEE with Z=1: pc held, taken_cnt unchanged. Redirect 0xBEEF together with stall and BNE: pc=0xBEEF, flush=1, taken_cnt unchanged.
- pc=0xFFFF with ADDR_W=16 and no branch: pc=0. CNT_W=2 with 5 JMPs: taken_cnt stays 3.
- PC_RAS_EN, RAS_DEPTH=2: CALL at pc 10, 20, 30, then RET x3 -> pc returns to 31, then 21, then pc+1 with ras_err=1 (entry 11 was overwritten).
